display_arbiter: RTL and testbench
==================================

// Module: display_arbiter
// PURPOSE
//  Shares the four-digit LED driver between three sources: transmitter status (tx), received data (rx) and an error code (err).
//  Arbitrates between the sources and registers the winning 16-bit word onto signal_to_display, which feeds FourDigitLEDdriver.
//  Each granted word stays on the display for a minimum time so that it is readable.
//  err pre-empts tx and rx. tx and rx share the display round-robin.
// PARAMETERS
//  HOLD_CYCLES  250  minimum cycles a granted tx/rx word is displayed; legal range 1..2^CNT_W-1
//  CNT_W        16   hold-counter width
// PORTS
//  clk                input   1   system clock; all logic on posedge
//  reset              input   1   synchronous, active-high
//  req_tx             input   1   tx request; level, held until ack_tx
//  data_tx            input   16  tx word; stable while req_tx is high
//  ack_tx             output  1   1-cycle pulse: tx word accepted
//  req_rx             input   1   rx request; level, held until ack_rx
//  data_rx            input   16  rx word; stable while req_rx is high
//  ack_rx             output  1   1-cycle pulse: rx word accepted
//  err_flag           input   1   level; error condition active
//  err_code           input   16  word shown while err_flag is high
//  signal_to_display  output  16  registered word to the LED driver
//  owner              output  2   current owner: 0 none, 1 tx, 2 rx, 3 err
//  busy               output  1   high when state != IDLE
// BEHAVIOUR
//  Reset values:
//   - signal_to_display=16'h0000, owner=0, ack_tx=ack_rx=0, busy=0
//   - state=IDLE, hold counter=0, last_grant=RX (so tx wins the first tie)
//  FSM states: IDLE, SHOW_TX, SHOW_RX, SHOW_ERR.
//  IDLE, evaluated in priority order each edge:
//   - err_flag -> SHOW_ERR
//   - else both req_tx and req_rx -> grant the source opposite to last_grant
//   - else the single requester is granted
//   - else stay in IDLE; signal_to_display keeps its last value
//  Grant of tx/rx at edge k:
//   - signal_to_display <= data_x, owner <= x, last_grant <= x, counter <= HOLD_CYCLES-1
//   - ack_x is high for exactly the cycle after edge k
//   - Latency: req sampled at edge k -> display updated at edge k+1 (one-cycle latency).
//  SHOW_TX / SHOW_RX:
//   - counter decrements each cycle; the word is held for HOLD_CYCLES cycles
//   - when counter==0 -> IDLE and owner <= 0; display value is retained
//   - Back-to-back grant period is therefore HOLD_CYCLES+1 cycles.
//  Requests:
//   - a request arriving during a hold waits; it is not acked until granted
//   - a req dropped before its ack is ignored; no ack is issued for it
//  Error handling:
//   - err_flag high in any state -> SHOW_ERR at the next edge, aborting any tx/rx hold
//   - the aborted word is not re-shown; it was already acked
//   - SHOW_ERR: signal_to_display <= err_code every cycle, so it tracks changes
//   - err_flag low -> IDLE; the display retains the last err_code and owner <= 0
//   - no ack is ever generated for err
//  Simultaneous events:
//   - err_flag together with req_x in IDLE -> err wins; req_x stays pending, no ack
//   - reset has priority over everything, including mid-hold and SHOW_ERR
//  Hold counter:
//   - width CNT_W; no wrap, it only decrements to 0
//   - HOLD_CYCLES=1 gives one display cycle then IDLE
//  Invariant: ack_tx and ack_rx are never high in the same cycle.
// STRUCTURE
//  display_pkg.vh:
//   - owner codes OWN_NONE/OWN_TX/OWN_RX/OWN_ERR
//   - FSM state encodings
//   - DISP_W=16
//  Sub-module hold_timer (load, load_val, expired; CNT_W down-counter) is instantiated once.
//  FSM, arbitration and output registers live in display_arbiter.
// TESTING (bench uses HOLD_CYCLES=4; one check per scenario)
//  1. Reset for 20 cycles, then release
//     -> signal_to_display=0000, owner=0, busy=0, no acks.
//  2. req_tx=1, data_tx=16'hA194, held until ack
//     -> display=A194 one edge after sampling, ack_tx pulses exactly 1 cycle,
//        owner=1 for 4 cycles, then IDLE with display still A194.
//  3. req_tx and req_rx (CC10) raised in the same cycle after reset
//     -> tx is granted first; rx is granted at the 5th edge after the tx grant;
//        acks never overlap.
//  4. rx word shown, err_flag raised in hold cycle 2 with err_code=EEE1
//     -> display=EEE1 at the next edge, owner=3.
//     Change err_code to EEE2 -> display follows.
//     Drop err_flag -> IDLE, display=EEE2.
//  5. err_flag and req_rx raised together in IDLE
//     -> no ack_rx while err_flag is high; ack_rx follows one edge after err_flag drops.
//  6. reset asserted in hold cycle 3 of a tx grant
//     -> all outputs return to reset values at that edge; the pending rx is then granted
//        normally after release.

Source files
------------

// File: rtl/display_pkg.sv
// Shared owner codes, FSM states and display width
// for the LED display arbiter.
package display_pkg;

  localparam int DISP_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_TX   = 2'd1,
    OWN_RX   = 2'd2,
    OWN_ERR  = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHOW_TX  = 2'd1,
    SHOW_RX  = 2'd2,
    SHOW_ERR = 2'd3
  } state_t;

endpackage

// File: rtl/display_arbiter_hold_timer.sv
// Down-counter that sets how long a granted word stays
// on the display; it stops at zero and never wraps.
module hold_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // load on grant, otherwise count down and stop at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates tx/rx/err onto the four-digit LED word:
// err pre-empts, tx and rx alternate round-robin.
module display_arbiter
  import display_pkg::*;
#(
  parameter int HOLD_CYCLES = 250,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_tx,
  input  logic [DISP_W-1:0] data_tx,
  output logic              ack_tx,
  input  logic              req_rx,
  input  logic [DISP_W-1:0] data_rx,
  output logic              ack_rx,
  input  logic              err_flag,
  input  logic [DISP_W-1:0] err_code,
  output logic [DISP_W-1:0] signal_to_display,
  output logic [1:0]        owner,
  output logic              busy
);

  state_t            state, state_n;
  owner_t            own_q, own_n;
  owner_t            last_q, last_n;
  logic [DISP_W-1:0] disp_q, disp_n;
  logic              atx_q, atx_n;
  logic              arx_q, arx_n;
  logic              load, expired;
  logic              tx_win, rx_win;

  hold_timer #(
    .CNT_W(CNT_W)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_val(CNT_W'(HOLD_CYCLES - 1)),
    .expired (expired)
  );

  // tx wins a tie only when rx was granted last
  assign tx_win = req_tx &&
                  (!req_rx || last_q == OWN_RX);
  assign rx_win = req_rx && !tx_win;

  // next-state, grant and output-word selection
  always_comb begin
    state_n = state;
    own_n   = own_q;
    last_n  = last_q;
    disp_n  = disp_q;
    atx_n   = 1'b0;
    arx_n   = 1'b0;
    load    = 1'b0;
    if (err_flag) begin
      state_n = SHOW_ERR;
      own_n   = OWN_ERR;
      disp_n  = err_code;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            tx_win: begin
              state_n = SHOW_TX;
              own_n   = OWN_TX;
              last_n  = OWN_TX;
              disp_n  = data_tx;
              atx_n   = 1'b1;
              load    = 1'b1;
            end
            rx_win: begin
              state_n = SHOW_RX;
              own_n   = OWN_RX;
              last_n  = OWN_RX;
              disp_n  = data_rx;
              arx_n   = 1'b1;
              load    = 1'b1;
            end
            default: ;
          endcase
        end
        SHOW_TX, SHOW_RX: begin
          if (expired) begin
            state_n = IDLE;
            own_n   = OWN_NONE;
          end
        end
        SHOW_ERR: begin
          state_n = IDLE;
          own_n   = OWN_NONE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      own_q  <= OWN_NONE;
      last_q <= OWN_RX;
      disp_q <= '0;
      atx_q  <= 1'b0;
      arx_q  <= 1'b0;
    end else begin
      state  <= state_n;
      own_q  <= own_n;
      last_q <= last_n;
      disp_q <= disp_n;
      atx_q  <= atx_n;
      arx_q  <= arx_n;
    end
  end

  assign signal_to_display = disp_q;
  assign owner             = own_q;
  assign ack_tx            = atx_q;
  assign ack_rx            = arx_q;
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_display_arbiter.sv
// Directed vector bench for display_arbiter
// with HOLD_CYCLES=4.
module tb_display_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_tx, req_rx, err_flag;
  logic [15:0] data_tx, data_rx, err_code;
  logic        ack_tx, ack_rx, busy;
  logic [15:0] signal_to_display;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, rtx, rrx, err;
    logic [15:0] dtx, drx, ecode;
    logic [15:0] edisp;
    logic [1:0]  eown;
    logic        eatx, earx, ebusy;
  } vec_t;

  vec_t vt[$];

  display_arbiter #(
    .HOLD_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_tx(req_tx),
    .data_tx(data_tx),
    .ack_tx(ack_tx),
    .req_rx(req_rx),
    .data_rx(data_rx),
    .ack_rx(ack_rx),
    .err_flag(err_flag),
    .err_code(err_code),
    .signal_to_display(signal_to_display),
    .owner(owner),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rst, rtx, rrx, err,
    input logic [15:0] dtx, drx, ecode, edisp,
    input logic [1:0] eown,
    input logic eatx, earx, ebusy);
    vec_t v;
    v.rst = rst; v.rtx = rtx; v.rrx = rrx;
    v.err = err; v.dtx = dtx; v.drx = drx;
    v.ecode = ecode; v.edisp = edisp;
    v.eown = eown; v.eatx = eatx;
    v.earx = earx; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req_tx = 0; req_rx = 0; err_flag = 0;
    data_tx = 0; data_rx = 0; err_code = 0;

    // rst rtx rrx err dtx drx ecode | disp own atx arx busy
    // single tx grant and full hold
    vt.push_back(mk(0,1,0,0,16'hA194,0,0, 16'hA194,1,1,0,1));
    vt.push_back(mk(0,0,0,0,16'hA194,0,0, 16'hA194,1,0,0,1));
    vt.push_back(mk(0,0,0,0,16'hA194,0,0, 16'hA194,1,0,0,1));
    vt.push_back(mk(0,0,0,0,16'hA194,0,0, 16'hA194,1,0,0,1));
    vt.push_back(mk(0,0,0,0,16'hA194,0,0, 16'hA194,0,0,0,0));
    vt.push_back(mk(0,0,0,0,16'hA194,0,0, 16'hA194,0,0,0,0));
    // reset, then tx/rx tie
    vt.push_back(mk(1,0,0,0,0,0,0, 16'h0000,0,0,0,0));
    vt.push_back(mk(0,1,1,0,16'h1234,16'hCC10,0, 16'h1234,1,1,0,1));
    vt.push_back(mk(0,0,1,0,16'h1234,16'hCC10,0, 16'h1234,1,0,0,1));
    vt.push_back(mk(0,0,1,0,16'h1234,16'hCC10,0, 16'h1234,1,0,0,1));
    vt.push_back(mk(0,0,1,0,16'h1234,16'hCC10,0, 16'h1234,1,0,0,1));
    vt.push_back(mk(0,0,1,0,16'h1234,16'hCC10,0, 16'h1234,0,0,0,0));
    vt.push_back(mk(0,0,1,0,16'h1234,16'hCC10,0, 16'hCC10,2,0,1,1));
    // err pre-empts rx hold, tracks code, drops
    vt.push_back(mk(0,0,0,0,0,16'hCC10,0, 16'hCC10,2,0,0,1));
    vt.push_back(mk(0,0,0,1,0,0,16'hEEE1, 16'hEEE1,3,0,0,1));
    vt.push_back(mk(0,0,0,1,0,0,16'hEEE2, 16'hEEE2,3,0,0,1));
    vt.push_back(mk(0,0,0,0,0,0,16'hEEE2, 16'hEEE2,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0, 16'hEEE2,0,0,0,0));
    // err and rx together in IDLE
    vt.push_back(mk(0,0,1,1,0,16'h5A5A,16'h0BAD, 16'h0BAD,3,0,0,1));
    vt.push_back(mk(0,0,1,1,0,16'h5A5A,16'h0BAD, 16'h0BAD,3,0,0,1));
    vt.push_back(mk(0,0,1,0,0,16'h5A5A,16'h0BAD, 16'h0BAD,0,0,0,0));
    vt.push_back(mk(0,0,1,0,0,16'h5A5A,0, 16'h5A5A,2,0,1,1));
    vt.push_back(mk(0,0,0,0,0,16'h5A5A,0, 16'h5A5A,2,0,0,1));
    vt.push_back(mk(0,0,0,0,0,0,0, 16'h5A5A,2,0,0,1));
    vt.push_back(mk(0,0,0,0,0,0,0, 16'h5A5A,2,0,0,1));
    vt.push_back(mk(0,0,0,0,0,0,0, 16'h5A5A,0,0,0,0));
    // reset mid tx hold, pending rx granted after
    vt.push_back(mk(0,1,1,0,16'h7777,16'h8888,0, 16'h7777,1,1,0,1));
    vt.push_back(mk(0,0,1,0,0,16'h8888,0, 16'h7777,1,0,0,1));
    vt.push_back(mk(0,0,1,0,0,16'h8888,0, 16'h7777,1,0,0,1));
    vt.push_back(mk(1,0,1,0,0,16'h8888,0, 16'h0000,0,0,0,0));
    vt.push_back(mk(0,0,1,0,0,16'h8888,0, 16'h8888,2,0,1,1));
    vt.push_back(mk(0,0,0,0,0,0,0, 16'h8888,2,0,0,1));

    // reset held for 20 cycles
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst disp", 32'(signal_to_display), 32'h0);
    chk("rst owner", 32'(owner), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst acks", 32'({ack_tx, ack_rx}), 32'h0);

    foreach (vt[i]) begin
      reset    = vt[i].rst;
      req_tx   = vt[i].rtx;
      req_rx   = vt[i].rrx;
      err_flag = vt[i].err;
      data_tx  = vt[i].dtx;
      data_rx  = vt[i].drx;
      err_code = vt[i].ecode;
      step();
      chk($sformatf("row%0d disp", i),
          32'(signal_to_display), 32'(vt[i].edisp));
      chk($sformatf("row%0d owner", i),
          32'(owner), 32'(vt[i].eown));
      chk($sformatf("row%0d ack_tx", i),
          32'(ack_tx), 32'(vt[i].eatx));
      chk($sformatf("row%0d ack_rx", i),
          32'(ack_rx), 32'(vt[i].earx));
      chk($sformatf("row%0d busy", i),
          32'(busy), 32'(vt[i].ebusy));
      chk($sformatf("row%0d ack_excl", i),
          32'(ack_tx & ack_rx), 32'h0);
    end

    // rx request withdrawn during a tx hold is never acked
    reset = 1'b1;
    req_tx = 0; req_rx = 0;
    step();
    reset = 1'b0;
    req_tx = 1; data_tx = 16'h1111;
    step();
    chk("drop tx ack", 32'(ack_tx), 32'h1);
    req_tx = 0;
    req_rx = 1; data_rx = 16'h2222;
    step();
    req_rx = 0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
        step();
        if (ack_rx) seen++;
      end
      chk("drop no ack_rx", 32'(seen), 32'h0);
    end
    chk("drop disp", 32'(signal_to_display), 32'h1111);

    // bounded wait for a fresh tx grant
    req_tx = 1; data_tx = 16'h3333;
    begin
      int got;
      got = 0;
      for (int c = 0; c < 8 && got == 0; c++) begin
        step();
        if (ack_tx) got = 1;
      end
      chk("wait ack_tx", 32'(got), 32'h1);
      chk("wait disp", 32'(signal_to_display), 32'h3333);
    end
    req_tx = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
